mem_arbiter: RTL

- Arbitrates one shared memory port between the instruction fetch unit and the load/store unit of the pipelined core.
- Each requester sees a private valid/ready request channel and a private valid/ready response channel.
- Grants one transaction at a time and round-robins on contention.
- Times out unanswered memory transactions with an error response so that a dead slave cannot hang the pipeline.

---
 rtl/mem_arbiter_if.sv | 64 ++++++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
//   Bundles the three handshake channels around the memory arbiter:
//   the instruction-fetch requester (if_*), the load/store requester (ls_*)
//   and the shared downstream memory port (mem_*).
//
//   modport master : arbiter view (accepts requester traffic, drives memory)
//   modport slave  : environment view (requesters and memory model)
//
//   Parameters ADDR_W / DATA_W / WMASK_W must match those of mem_arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int WMASK_W = 8
);
  // IFU channels (read only)
  logic               if_req_valid;
  logic               if_req_ready;
  logic [ADDR_W-1:0]  if_addr;
  logic               if_resp_valid;
  logic               if_resp_ready;
  logic [DATA_W-1:0]  if_rdata;
  logic               if_resp_err;

  // LSU channels
  logic               ls_req_valid;
  logic               ls_req_ready;
  logic [ADDR_W-1:0]  ls_addr;
  logic               ls_wen;
  logic [DATA_W-1:0]  ls_wdata;
  logic [WMASK_W-1:0] ls_wmask;
  logic               ls_resp_valid;
  logic               ls_resp_ready;
  logic [DATA_W-1:0]  ls_rdata;
  logic               ls_resp_err;

  // Shared memory port
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_wen;
  logic [DATA_W-1:0]  mem_wdata;
  logic [WMASK_W-1:0] mem_wmask;
  logic               mem_resp_valid;
  logic               mem_resp_ready;
  logic [DATA_W-1:0]  mem_rdata;

  modport master (
    input  if_req_valid, if_addr, if_resp_ready,
    output if_req_ready, if_resp_valid, if_rdata, if_resp_err,
    input  ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask, ls_resp_ready,
    output ls_req_ready, ls_resp_valid, ls_rdata, ls_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_rdata
  );

  modport slave (
    output if_req_valid, if_addr, if_resp_ready,
    input  if_req_ready, if_resp_valid, if_rdata, if_resp_err,
    output ls_req_valid, ls_addr, ls_wen, ls_wdata, ls_wmask, ls_resp_ready,
    input  ls_req_ready, ls_resp_valid, ls_rdata, ls_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, mem_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between the instruction fetch unit and the
//   load/store unit. One transaction is in flight at a time; on contention
//   the requester that was not served last wins. A memory response that
//   does not arrive within TIMEOUT cycles is answered with an error so a
//   dead slave cannot stall the pipeline.
//
//   Ports:
//     clk       rising-edge clock
//     rst       asynchronous active-low reset
//     bus       mem_arbiter_if.master (IFU, LSU and memory channels)
//     busy      transaction in progress (state is not IDLE)
//     grant_ls  current or most recent owner is the LSU
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int WMASK_W = 8,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus,
  output logic          busy,
  output logic          grant_ls
);

  // A TIMEOUT of 0 still needs a one-bit counter to keep the logic legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t             state;
  logic               grant_ls_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               wen_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [WMASK_W-1:0] wmask_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               mem_req_valid_q;
  logic               if_resp_valid_q;
  logic               ls_resp_valid_q;
  logic               busy_q;

  logic pick_ls;
  logic accept_if;
  logic accept_ls;
  logic owner_resp_ready;

  // Arbitration: the LSU wins when it is alone or when the IFU was served
  // last. Readies are gated by rst so nothing handshakes while in reset.
  assign pick_ls   = bus.ls_req_valid & (~bus.if_req_valid | ~grant_ls_q);
  assign accept_ls = (state == IDLE) & rst & pick_ls;
  assign accept_if = (state == IDLE) & rst & bus.if_req_valid & ~pick_ls;

  assign owner_resp_ready = grant_ls_q ? bus.ls_resp_ready : bus.if_resp_ready;

  assign bus.if_req_ready   = accept_if;
  assign bus.ls_req_ready   = accept_ls;
  assign bus.mem_req_valid  = mem_req_valid_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wen        = wen_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_wmask      = wmask_q;
  // Responses are also drained in IDLE so a late reply to a timed-out
  // request is swallowed rather than left pending on the bus.
  assign bus.mem_resp_ready = rst & ((state == IDLE) | (state == WAIT));
  assign bus.if_resp_valid  = if_resp_valid_q;
  assign bus.ls_resp_valid  = ls_resp_valid_q;
  assign bus.if_rdata       = rdata_q;
  assign bus.ls_rdata       = rdata_q;
  assign bus.if_resp_err    = err_q & ~grant_ls_q;
  assign bus.ls_resp_err    = err_q & grant_ls_q;
  assign busy               = busy_q;
  assign grant_ls           = grant_ls_q;

  // Transaction FSM. All visible valids and data are registered here; an
  // asynchronous reset abandons any in-flight transaction silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      grant_ls_q      <= 1'b0;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      wmask_q         <= '0;
      rdata_q         <= '0;
      err_q           <= 1'b0;
      cnt_q           <= '0;
      mem_req_valid_q <= 1'b0;
      if_resp_valid_q <= 1'b0;
      ls_resp_valid_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept_ls || accept_if) begin
            state           <= REQ;
            grant_ls_q      <= accept_ls;
            addr_q          <= accept_ls ? bus.ls_addr : bus.if_addr;
            wen_q           <= accept_ls & bus.ls_wen;
            wdata_q         <= accept_ls ? bus.ls_wdata : '0;
            wmask_q         <= accept_ls ? bus.ls_wmask : '0;
            mem_req_valid_q <= 1'b1;
            busy_q          <= 1'b1;
          end
        end
        REQ: begin
          if (bus.mem_req_ready) begin
            state           <= WAIT;
            mem_req_valid_q <= 1'b0;
            cnt_q           <= '0;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          // A response in the timeout cycle takes priority over the error.
          if (bus.mem_resp_valid) begin
            state           <= RESP;
            rdata_q         <= wen_q ? '0 : bus.mem_rdata;
            err_q           <= 1'b0;
            if_resp_valid_q <= ~grant_ls_q;
            ls_resp_valid_q <= grant_ls_q;
          end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
            state           <= RESP;
            rdata_q         <= '0;
            err_q           <= 1'b1;
            if_resp_valid_q <= ~grant_ls_q;
            ls_resp_valid_q <= grant_ls_q;
          end
        end
        RESP: begin
          if (owner_resp_ready) begin
            state           <= IDLE;
            if_resp_valid_q <= 1'b0;
            ls_resp_valid_q <= 1'b0;
            busy_q          <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
